// File: rtl/thermal_overheat_detector.sv
// Thermal overheat detector: turns a raw sampled CPU temperature stream into a
// debounced, hysteretic overheat flag with a sensor-fault fail-safe.
//
// Ports:
//   clk            - rising-edge clock
//   rst_n          - asynchronous active-low reset
//   temp_valid     - temp carries a new sample this cycle
//   temp           - unsigned temperature sample
//   sensor_fault   - sensor reports invalid data (level)
//   cpu_overheated - registered overheat flag (HOT, COOLING, FAULT)
//   peak_temp      - registered max valid sample since last entry to COOL
//   overheat_state - registered FSM state for debug
module thermal_overheat_detector #(
  parameter int unsigned TEMP_W     = 8,
  parameter int unsigned HI_THRESH  = 90,
  parameter int unsigned LO_THRESH  = 75,
  parameter int unsigned ASSERT_CNT = 4,
  parameter int unsigned CLEAR_CNT  = 8,
  parameter int unsigned CNT_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              temp_valid,
  input  logic [TEMP_W-1:0] temp,
  input  logic              sensor_fault,
  output logic              cpu_overheated,
  output logic [TEMP_W-1:0] peak_temp,
  output logic [2:0]        overheat_state
);

  typedef enum logic [2:0] {
    ST_COOL    = 3'd0,
    ST_HEATING = 3'd1,
    ST_HOT     = 3'd2,
    ST_COOLING = 3'd3,
    ST_FAULT   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TEMP_W-1:0]  peak_d;
  logic               flag_d;
  logic               is_hot, is_cool;
  logic               peak_upd, peak_clr;
  logic [CNT_W-1:0]   cnt_inc;

  assign is_hot  = temp >= TEMP_W'(HI_THRESH);
  assign is_cool = temp <= TEMP_W'(LO_THRESH);
  assign cnt_inc = cnt_q + CNT_W'(1);

  // Next-state, run counter and peak-tracking control
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    peak_upd = 1'b0;
    peak_clr = 1'b0;

    if (sensor_fault) begin
      // Fault overrides any temperature transition in the same cycle
      state_d = ST_FAULT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_COOL: begin
          if (temp_valid) begin
            peak_upd = 1'b1;
            if (is_hot) begin
              if (ASSERT_CNT == 1) begin
                state_d = ST_HOT;
                cnt_d   = '0;
              end else begin
                state_d = ST_HEATING;
                cnt_d   = CNT_W'(1);
              end
            end
          end
        end
        ST_HEATING: begin
          if (temp_valid) begin
            peak_upd = 1'b1;
            if (is_hot) begin
              if (cnt_inc == CNT_W'(ASSERT_CNT)) begin
                state_d = ST_HOT;
                cnt_d   = '0;
              end else begin
                cnt_d = cnt_inc;
              end
            end else begin
              state_d = ST_COOL;
              cnt_d   = '0;
            end
          end
        end
        ST_HOT: begin
          if (temp_valid) begin
            if (is_cool) begin
              if (CLEAR_CNT == 1) begin
                // Immediate deassert behaves like finishing the cool-down
                state_d  = ST_COOL;
                cnt_d    = '0;
                peak_clr = 1'b1;
              end else begin
                state_d  = ST_COOLING;
                cnt_d    = CNT_W'(1);
                peak_upd = 1'b1;
              end
            end else begin
              peak_upd = 1'b1;
            end
          end
        end
        ST_COOLING: begin
          if (temp_valid) begin
            if (is_cool) begin
              if (cnt_inc == CNT_W'(CLEAR_CNT)) begin
                state_d  = ST_COOL;
                cnt_d    = '0;
                peak_clr = 1'b1;
              end else begin
                cnt_d    = cnt_inc;
                peak_upd = 1'b1;
              end
            end else begin
              state_d  = ST_HOT;
              cnt_d    = '0;
              peak_upd = 1'b1;
            end
          end
        end
        ST_FAULT: begin
          // Recovery always goes through the full cool-down
          state_d = ST_HOT;
          cnt_d   = '0;
        end
        default: begin
          state_d = ST_COOL;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Peak tracker and flag derived from the next state
  always_comb begin
    peak_d = peak_temp;
    if (peak_clr) begin
      peak_d = '0;
    end else if (peak_upd && (temp > peak_temp)) begin
      peak_d = temp;
    end
    flag_d = (state_d == ST_HOT) || (state_d == ST_COOLING) || (state_d == ST_FAULT);
  end

  // State, counter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_COOL;
      cnt_q          <= '0;
      cpu_overheated <= 1'b0;
      peak_temp      <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      cpu_overheated <= flag_d;
      peak_temp      <= peak_d;
    end
  end

  assign overheat_state = state_q;

endmodule
